// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI-to-memory bridge: host command opcodes and
// the frame-decoder state encoding.
package spi_bridge_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h0B;
  localparam logic [7:0] CMD_STATUS = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_WDATA,
    ST_RDATA,
    ST_STATUS,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/spi_mem_bridge_sync_edge.sv
// sync_edge: multi-stage synchronizer for one asynchronous input, with
// rise/fall pulses derived from the synchronized level.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input pin
//   q        : synchronized level
//   rise     : one-cycle pulse on a synchronized 0->1 transition
//   fall     : one-cycle pulse on a synchronized 1->0 transition
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge: SPI mode-0 responder giving an external host read/write
// access to the SoC memory bus (valid/ready initiator).
// Frame: 8-bit command, 32-bit address MSB first, then payload.
//   0x02 WRITE  : 32 data bits follow, issued as one word write
//   0x0B READ   : 8 dummy bits, then 32 read-data bits on MISO
//   0x05 STATUS : repeating byte {7'b0, busy}
// Ports:
//   clk, rst                 : system clock, synchronous active-high reset
//   spi_csb/spi_sck/spi_mosi : host pins, asynchronous to clk
//   spi_miso, spi_miso_oe    : response data and its drive enable
//   mem_valid/ready/addr/wdata/wstrb/rdata : SoC memory bus initiator
module spi_mem_bridge
  import spi_bridge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_csb,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  logic csb_s, csb_rise, csb_fall;
  logic sck_rise, sck_fall, sck_level_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csb (
    .clk(clk), .rst(rst), .d(spi_csb), .q(csb_s), .rise(csb_rise), .fall(csb_fall)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .d(spi_sck), .q(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_e      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [30:0] sr_in;
  logic [31:0] sr_out;
  logic [7:0]  cmd_q;
  logic [29:0] addr_q;
  logic [31:0] rdata_q;
  logic [31:0] word;
  logic        active, last_rise_32, issue_wr, issue_rd;

  // word is the shift register including the bit being sampled right now
  assign word         = {sr_in, mosi_s};
  assign active       = ~csb_s & ~csb_fall;
  assign last_rise_32 = active & sck_rise & (cnt_q == 6'd31);
  // A request already in flight blocks a new one; the host polls STATUS.
  assign issue_wr = last_rise_32 & (state_q == ST_WDATA) & ~mem_valid;
  assign issue_rd = last_rise_32 & (state_q == ST_ADDR) & (cmd_q == CMD_READ) & ~mem_valid;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (csb_rise) begin
      state_d = ST_IDLE;
    end else if (csb_fall) begin
      state_d = ST_CMD;
    end else if (active) begin
      unique case (state_q)
        ST_CMD: if (sck_rise && cnt_q == 6'd7) begin
          if (word[7:0] == CMD_WRITE || word[7:0] == CMD_READ) state_d = ST_ADDR;
          else if (word[7:0] == CMD_STATUS)                    state_d = ST_STATUS;
          else                                                 state_d = ST_IGNORE;
        end
        ST_ADDR:  if (last_rise_32) state_d = (cmd_q == CMD_READ) ? ST_DUMMY : ST_WDATA;
        ST_WDATA: if (last_rise_32) state_d = ST_IGNORE;
        ST_DUMMY: if (sck_fall && cnt_q == 6'd8) state_d = ST_RDATA;
        ST_RDATA: if (sck_fall && cnt_q == 6'd32) state_d = ST_IGNORE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      sr_in     <= '0;
      sr_out    <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      rdata_q   <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      // Bus side runs independently of the frame so an issued request
      // always completes, even across csb aborts.
      if (mem_valid && mem_ready) begin
        mem_valid <= 1'b0;
        if (mem_wstrb == 4'b0000) rdata_q <= mem_rdata;
      end
      if (issue_wr) begin
        mem_valid <= 1'b1;
        mem_addr  <= {addr_q, 2'b00};
        mem_wdata <= word;
        mem_wstrb <= '1;
      end
      if (issue_rd) begin
        mem_valid <= 1'b1;
        mem_addr  <= {word[31:2], 2'b00};
        mem_wstrb <= '0;
        rdata_q   <= '0;
      end

      if (csb_rise || csb_fall) begin
        cnt_q  <= '0;
        sr_out <= '0;
      end else if (active) begin
        if (sck_rise) begin
          sr_in <= word[30:0];
          if (state_d != state_q)         cnt_q <= '0;
          else if (state_q == ST_STATUS)  cnt_q <= (cnt_q == 6'd7) ? 6'd0 : cnt_q + 6'd1;
          else if (state_q != ST_IGNORE)  cnt_q <= cnt_q + 6'd1;
          if (state_q == ST_CMD && cnt_q == 6'd7) cmd_q <= word[7:0];
          if (state_q == ST_ADDR && cnt_q == 6'd31) begin
            addr_q <= word[31:2];
            sr_out <= '0;
          end
        end
        if (sck_fall) begin
          unique case (state_q)
            ST_DUMMY: if (cnt_q == 6'd8) begin
              sr_out <= rdata_q;
              cnt_q  <= '0;
            end
            ST_RDATA: sr_out <= {sr_out[30:0], 1'b0};
            // Status byte reloads at each byte boundary so busy is fresh.
            ST_STATUS: begin
              if (cnt_q == 6'd0) sr_out <= {7'b0, mem_valid, 24'b0};
              else               sr_out <= {sr_out[30:0], 1'b0};
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign spi_miso_oe = ~csb_s & ((state_q == ST_DUMMY) || (state_q == ST_RDATA) || (state_q == ST_STATUS));
  assign spi_miso    = spi_miso_oe & sr_out[31];

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Directed self-checking bench for spi_mem_bridge: an SPI host driver, a
// memory responder with configurable latency, and scoreboards for expected
// bus requests and expected MISO read words.
module tb_spi_mem_bridge;
  import spi_bridge_pkg::*;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_csb, spi_sck, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  spi_mem_bridge #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .spi_csb(spi_csb), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  req_t        exp_req_q[$];
  logic [31:0] exp_miso_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  bit          pending, ready_now, hold_ready;
  int          wait_c, resp_delay, req_count;
  logic [31:0] resp_data;

  initial begin
    req_t e, cur;
    mem_ready = 1'b0;
    mem_rdata = '0;
    pending   = 0;
    ready_now = 0;
    req_count = 0;
    cur       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending   = 0;
        ready_now = 0;
        mem_ready = 1'b0;
      end else if (ready_now) begin
        mem_ready = 1'b0;
        ready_now = 0;
        pending   = 0;
        check("valid_drop_after_ready", {31'b0, mem_valid}, 32'd0);
      end else if (pending) begin
        if (!hold_ready) begin
          wait_c++;
          if (wait_c >= resp_delay) begin
            check("hold_addr", mem_addr, cur.addr);
            check("hold_wstrb", {28'b0, mem_wstrb}, {28'b0, cur.wstrb});
            mem_rdata = resp_data;
            mem_ready = 1'b1;
            ready_now = 1;
          end
        end
      end else if (mem_valid) begin
        pending = 1;
        wait_c  = 0;
        req_count++;
        check("req_expected", 32'(exp_req_q.size() != 0), 32'd1);
        if (exp_req_q.size() != 0) begin
          e = exp_req_q.pop_front();
          cur = e;
          check("req_addr", mem_addr, e.addr);
          check("req_wstrb", {28'b0, mem_wstrb}, {28'b0, e.wstrb});
          if (e.wstrb == 4'hF) check("req_wdata", mem_wdata, e.wdata);
        end
      end
    end
  end

  // ---------------- SPI host ----------------
  int bit_idx, oe_first, oe_cnt;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic r);
    spi_mosi = b;
    tick(HALF);
    r = spi_miso;
    if (spi_miso_oe) begin
      if (oe_cnt == 0) oe_first = bit_idx;
      oe_cnt++;
    end
    bit_idx++;
    spi_sck = 1'b1;
    tick(HALF);
    spi_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic cs_low();
    bit_idx  = 0;
    oe_first = -1;
    oe_cnt   = 0;
    spi_csb  = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_high();
    tick(HALF);
    spi_csb = 1'b1;
    tick(2 * HALF);
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [7:0] rx;
    for (int i = 3; i >= 0; i--) spi_byte(w[i*8 +: 8], rx);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    logic [7:0] rx;
    cs_low();
    spi_byte(CMD_WRITE, rx);
    send_word(a);
    send_word(d);
    cs_high();
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    logic [7:0] rx;
    cs_low();
    spi_byte(CMD_READ, rx);
    send_word(a);
    spi_byte(8'h00, rx);
    for (int i = 3; i >= 0; i--) begin
      spi_byte(8'h00, rx);
      d[i*8 +: 8] = rx;
    end
    cs_high();
  endtask

  task automatic do_status(input int nbytes, input logic [7:0] exp, input string tag);
    logic [7:0] rx;
    cs_low();
    spi_byte(CMD_STATUS, rx);
    for (int i = 0; i < nbytes; i++) begin
      spi_byte(8'h00, rx);
      check(tag, {24'b0, rx}, {24'b0, exp});
    end
    cs_high();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  rx, rx_or;
    logic        r;
    int          n0;

    rst = 1'b1; spi_csb = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    hold_ready = 0; resp_delay = 3; resp_data = '0;
    tick(5);
    check("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    check("rst_miso", {31'b0, spi_miso}, 32'd0);
    check("rst_miso_oe", {31'b0, spi_miso_oe}, 32'd0);
    rst = 1'b0;
    tick(5);

    // WRITE with 3-clk responder
    n0 = req_count;
    exp_req_q.push_back('{addr: 32'h0300_0000, wdata: 32'h0000_0001, wstrb: 4'hF});
    do_write(32'h0300_0000, 32'h0000_0001);
    tick(10);
    check("write_req_count", 32'(req_count - n0), 32'd1);
    check("write_oe_cnt", 32'(oe_cnt), 32'd0);

    // READ, responder answers after 5 clk
    resp_delay = 5;
    resp_data  = 32'hCAFE_F00D;
    exp_req_q.push_back('{addr: 32'h0000_0104, wdata: '0, wstrb: 4'h0});
    exp_miso_q.push_back(32'hCAFE_F00D);
    do_read(32'h0000_0104, d);
    check("read_data", d, exp_miso_q.pop_front());
    check("read_oe_first_bit", 32'(oe_first), 32'd40);
    check("read_oe_bits", 32'(oe_cnt), 32'd40);

    // READ with unaligned address
    resp_data = 32'h1234_5678;
    exp_req_q.push_back('{addr: 32'h0000_0104, wdata: '0, wstrb: 4'h0});
    exp_miso_q.push_back(32'h1234_5678);
    do_read(32'h0000_0107, d);
    check("read_unaligned_data", d, exp_miso_q.pop_front());

    // Busy: held write, second write dropped, STATUS polling
    hold_ready = 1;
    exp_req_q.push_back('{addr: 32'h0000_0010, wdata: 32'hA5A5_5A5A, wstrb: 4'hF});
    do_write(32'h0000_0010, 32'hA5A5_5A5A);
    do_write(32'h0000_0020, 32'hDEAD_BEEF);
    do_status(2, 8'h01, "status_busy");
    tick(200);
    check("busy_valid_held", {31'b0, mem_valid}, 32'd1);
    hold_ready = 0;
    tick(20);
    check("busy_valid_released", {31'b0, mem_valid}, 32'd0);
    do_status(1, 8'h00, "status_idle");

    // csb abort after 20 address bits
    n0 = req_count;
    cs_low();
    spi_byte(CMD_WRITE, rx);
    for (int i = 0; i < 20; i++) spi_bit(1'b1, r);
    cs_high();
    tick(10);
    check("abort_no_req", 32'(req_count - n0), 32'd0);
    check("abort_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    do_status(1, 8'h00, "status_after_abort");

    // Unknown command
    n0 = req_count;
    rx_or = '0;
    cs_low();
    spi_byte(8'h9F, rx);
    for (int i = 0; i < 5; i++) begin
      spi_byte(8'hFF, rx);
      rx_or = rx_or | rx;
    end
    cs_high();
    tick(10);
    check("unknown_oe_cnt", 32'(oe_cnt), 32'd0);
    check("unknown_miso", {24'b0, rx_or}, 32'd0);
    check("unknown_no_req", 32'(req_count - n0), 32'd0);

    // Reset during a pending write
    hold_ready = 1;
    exp_req_q.push_back('{addr: 32'h0000_0040, wdata: 32'h0000_0055, wstrb: 4'hF});
    do_write(32'h0000_0040, 32'h0000_0055);
    tick(2);
    check("pending_valid", {31'b0, mem_valid}, 32'd1);
    rst = 1'b1;
    tick(1);
    check("rst_drops_valid", {31'b0, mem_valid}, 32'd0);
    rst = 1'b0;
    hold_ready = 0;
    tick(5);
    check("valid_stays_low", {31'b0, mem_valid}, 32'd0);

    check("req_scoreboard_empty", 32'(exp_req_q.size()), 32'd0);
    check("miso_scoreboard_empty", 32'(exp_miso_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_mem_bridge.md
# spi_mem_bridge

SPI responder (mode 0, single-bit MOSI/MISO) that lets an external host read and write the SoC memory space. It decodes host command frames and acts as an initiator on the SoC `mem_*` valid/ready bus, the same bus that feeds `soc` iomem responders such as `mem_gpio`. It serves as a debug/load port alongside the SoC's own SPI flash master, which drives the flash pins as initiator.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages on `spi_csb`, `spi_sck` and `spi_mosi`; legal values 2..3.

Ports:
- `clk` in 1: system clock; all logic is on posedge.
- `rst` in 1: reset; synchronous, active-high.
- `spi_csb` in 1: host chip select, active low; asynchronous to `clk`.
- `spi_sck` in 1: host clock, idle low; asynchronous.
- `spi_mosi` in 1: host data, MSB first.
- `spi_miso` out 1: response data.
- `spi_miso_oe` out 1: drive enable for the top-level SB_IO.
- `mem_valid` out 1: bus request.
- `mem_ready` in 1: bus completion, one cycle.
- `mem_addr` out 32: word address; bits [1:0] are always 0.
- `mem_wdata` out 32: write data.
- `mem_wstrb` out 4: 4'b1111 for a write, 4'b0000 for a read.
- `mem_rdata` in 32: read data, valid when `mem_ready` is high.

## Operation
- All SPI inputs pass through the synchronizer. Edges are detected on the synchronized `sck`:
  - MOSI is sampled on the rise.
  - MISO is shifted on the fall.
- A synchronized `csb` rise aborts the frame: the FSM goes to IDLE and the bit counter clears.
- Frame layout: 8-bit command, 32-bit address (MSB first), then payload.
- FSM states: IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, STATUS, IGNORE.
  - IDLE -> CMD on a `csb` fall.
  - CMD -> after 8 bits, the next state depends on the command.
- Command 0x02 (WRITE): CMD -> ADDR -> WDATA.
  - After 32 data bits, latch `mem_wdata` and `mem_addr` and raise `mem_valid`.
  - Extra bits go to IGNORE.
- Command 0x0B (READ): CMD -> ADDR.
  - After the address bits, raise `mem_valid` with `wstrb` 0, then go to DUMMY for 8 bits.
  - `rdata_q` is captured on `mem_ready`. It is cleared to 0 when the READ is issued.
  - At the `sck` fall ending DUMMY, load the shift register from `rdata_q`, then go to RDATA for 32 bits, then IGNORE.
- Command 0x05 (STATUS): CMD -> STATUS.
  - Shifts out byte {7'b0, busy}, repeated while `csb` stays low.
  - `busy` = `mem_valid`.
- Any other command goes to IGNORE until `csb` rises. MISO is 0.
- Bus request rules:
  - `mem_valid`, `mem_addr`, `mem_wdata` and `mem_wstrb` stay stable from assertion until the cycle `mem_ready` is seen high. `mem_valid` drops the next cycle.
  - A request already issued completes even if `csb` rises or a new frame starts.
  - A new WRITE or READ while busy is dropped (no second request). The host must poll STATUS.
- `spi_miso_oe` = `csb` synchronized low AND state is in {DUMMY, RDATA, STATUS}. `spi_miso` = shift-register MSB, otherwise 0.

## Timing
- Reset values: `mem_valid` 0, `mem_addr` 0, `mem_wdata` 0, `mem_wstrb` 0, `spi_miso` 0, `spi_miso_oe` 0, FSM IDLE, `rdata_q` 0.
- Input latency: SYNC_STAGES+1 clk from pin to edge detection.
- SCK frequency must be at most clk/8. Each SCK phase lasts at least 4 clk.
- WRITE: `mem_valid` rises 1 clk after the 72nd rise is detected.
- READ: `mem_valid` rises 1 clk after the 40th rise is detected.
  - If `mem_ready` has not arrived by the DUMMY-end fall, the shifted data is 0x00000000 and `busy` stays 1.
- Simultaneous `mem_ready` and `csb` abort: the response is accepted and `mem_valid` drops.
- `rst` mid-transaction: `mem_valid` drops immediately. An in-flight bus request is abandoned.

## Structure
- Shared package `spi_bridge_pkg`:
  - Command constants CMD_WRITE=8'h02, CMD_READ=8'h0B, CMD_STATUS=8'h05.
  - FSM state enum.
- Sub-module `sync_edge`: synchronizer plus rise/fall detect, one instance per input.
- Top level hooks up as an `iomem_*` master via an arbiter into `soc`, and `spi_miso` through SB_IO PIN_TYPE 6'b101001.

## Test plan
- WRITE 0x02, addr 0x03000000, data 0x00000001 -> one `mem_valid` with `wstrb` 4'hF, addr 0x03000000, `wdata` 0x00000001; `mem_ready` after 3 clk -> `mem_valid` low the next cycle.
- READ 0x0B, addr 0x00000104, responder returns 0xCAFEF00D after 5 clk -> MISO bits 48..79 = 0xCAFEF00D, `oe` high only during DUMMY/RDATA.
- READ with addr 0x00000107 -> `mem_addr` = 0x00000104.
- WRITE with `mem_ready` held low for 200 clk, then STATUS -> MISO byte 0x01; after ready, STATUS -> 0x00.
- `csb` rises after 20 address bits -> no `mem_valid`, FSM IDLE; the next STATUS frame returns 0x00.
- Unknown command 0x9F followed by 40 bits -> no bus request, `spi_miso_oe` 0 throughout; `rst` asserted during a pending write -> `mem_valid` 0 on the following cycle.
